// File: rtl/pipe_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU opcodes, forward-select
// codes and the hard-wired zero register number.
package pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_NOR  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_BEQ  = 4'b0110,
    ALU_BNE  = 4'b0111,
    ALU_BGEZ = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding for one EX source register: EX/MEM beats MEM/WB beats the
// value read in ID. Register zero is never forwarded.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic [DATA_W-1:0]     fwd_data
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (exmem_reg_write && (exmem_rd != ZERO_ADDR) && (exmem_rd == src_addr)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != ZERO_ADDR) && (memwb_rd == src_addr)) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_data = reg_data;
    case (sel)
      FWD_EXMEM: fwd_data = exmem_result;
      FWD_MEMWB: fwd_data = memwb_result;
      default:   fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use hazard
// detection, bubble insertion and a saturating stall-bubble counter.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_alu_ctrl,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_branch,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     alu_entr1,
  output logic [DATA_W-1:0]     alu_entr2,
  output logic [3:0]            alu_ctrl,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_branch,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(REG_ZERO);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [3:0]            alu_ctrl;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  branch;
  } ex_regs_t;

  ex_regs_t          ex_q, ex_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              uses_rt;
  logic              hazard;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // An immediate-form ALU op ignores rt, so a pending load into rt is harmless.
  assign uses_rt = !id_alu_src || id_mem_write || id_branch;
  assign hazard  = ex_q.valid && ex_q.mem_read && (ex_q.dest != ZERO_ADDR) && id_valid &&
                   ((ex_q.dest == id_rs) || ((ex_q.dest == id_rt) && uses_rt));
  assign stall   = hazard && !flush;

  always_comb begin
    ex_d          = '0;
    ex_d.alu_ctrl = 4'(ALU_ADD);
    if (!flush && !stall) begin
      ex_d.valid      = id_valid;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.dest       = id_reg_dst ? id_rd : id_rt;
      ex_d.rs_data    = id_rs_data;
      ex_d.rt_data    = id_rt_data;
      ex_d.imm        = id_imm;
      ex_d.alu_ctrl   = id_alu_ctrl;
      ex_d.alu_src    = id_alu_src;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.branch     = id_branch;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q          <= '0;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      stall_count_q <= stall_count_d;
    end
  end

  fwd_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_addr        (ex_q.rs),
    .reg_data        (ex_q.rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs)
  );

  fwd_sel #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_addr        (ex_q.rt),
    .reg_data        (ex_q.rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rt)
  );

  assign ex_valid      = ex_q.valid;
  assign alu_entr1     = fwd_rs;
  assign alu_entr2     = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_store_data = fwd_rt;
  assign ex_dest       = ex_q.dest;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_branch     = ex_q.branch;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: per-cycle vector table with hand-derived
// expectations fed through a scoreboard queue, plus a saturation sequence.
module tb_id_ex_operand_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic [3:0]    id_alu_ctrl;
  logic          id_alu_src, id_reg_dst;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic          flush;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_reg_write;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;
  logic          stall, ex_valid;
  logic [DW-1:0] alu_entr1, alu_entr2, ex_store_data;
  logic [3:0]    alu_ctrl;
  logic [AW-1:0] ex_dest;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic [CW-1:0] stall_count;

  id_ex_operand_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .alu_entr1(alu_entr1), .alu_entr2(alu_entr2),
    .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .stall_count(stall_count)
  );

  // ctl order: {reg_write, mem_read, mem_write, mem_to_reg, branch}
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [3:0]    ctrl;
    logic          alu_src, reg_dst;
    logic [4:0]    ctl;
  } id_t;

  typedef struct packed {
    logic          exm_we;
    logic [AW-1:0] exm_rd;
    logic [DW-1:0] exm_res;
    logic          mwb_we;
    logic [AW-1:0] mwb_rd;
    logic [DW-1:0] mwb_res;
  } fwd_t;

  typedef struct packed {
    logic          stall, valid;
    logic [DW-1:0] e1, e2, st;
    logic [3:0]    ctrl;
    logic [AW-1:0] dest;
    logic [4:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    id_t  id;
    logic flush;
    fwd_t fwd;
    exp_t exp;
  } vec_t;

  localparam int NV = 17;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  vec_t vecs[NV];

  function automatic id_t mk_id(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                input logic [AW-1:0] rd, input logic [DW-1:0] rsd,
                                input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                                input logic [3:0] ctrl, input logic alu_src,
                                input logic reg_dst, input logic [4:0] ctl);
    return '{1'b1, rs, rt, rd, rsd, rtd, imm, ctrl, alu_src, reg_dst, ctl};
  endfunction

  function automatic fwd_t mk_fwd(input logic exm_we, input logic [AW-1:0] exm_rd,
                                  input logic [DW-1:0] exm_res, input logic mwb_we,
                                  input logic [AW-1:0] mwb_rd, input logic [DW-1:0] mwb_res);
    return '{exm_we, exm_rd, exm_res, mwb_we, mwb_rd, mwb_res};
  endfunction

  function automatic exp_t mk_exp(input logic stall_e, input logic valid_e,
                                  input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                                  input logic [DW-1:0] st, input logic [3:0] ctrl,
                                  input logic [AW-1:0] dest, input logic [4:0] ctl,
                                  input logic [CW-1:0] cnt);
    return '{stall_e, valid_e, e1, e2, st, ctrl, dest, ctl, cnt};
  endfunction

  function automatic exp_t bubble(input logic [CW-1:0] cnt);
    return mk_exp(1'b0, 1'b0, '0, '0, '0, 4'b0000, '0, 5'b00000, cnt);
  endfunction

  function automatic id_t lw4(input logic [DW-1:0] imm);
    return mk_id(5'd1, 5'd4, 5'd0, 32'h100, 32'h999, imm, ALU_ADD, 1'b1, 1'b0, 5'b11010);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input id_t id, input logic fl, input fwd_t f);
    id_valid        = id.valid;
    id_rs           = id.rs;
    id_rt           = id.rt;
    id_rd           = id.rd;
    id_rs_data      = id.rs_data;
    id_rt_data      = id.rt_data;
    id_imm          = id.imm;
    id_alu_ctrl     = id.ctrl;
    id_alu_src      = id.alu_src;
    id_reg_dst      = id.reg_dst;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = id.ctl;
    flush           = fl;
    exmem_reg_write = f.exm_we;
    exmem_rd        = f.exm_rd;
    exmem_result    = f.exm_res;
    memwb_reg_write = f.mwb_we;
    memwb_rd        = f.mwb_rd;
    memwb_result    = f.mwb_res;
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, " stall"},      32'(stall),         32'(e.stall));
    check({tag, " ex_valid"},   32'(ex_valid),      32'(e.valid));
    check({tag, " alu_entr1"},  alu_entr1,          e.e1);
    check({tag, " alu_entr2"},  alu_entr2,          e.e2);
    check({tag, " store_data"}, ex_store_data,      e.st);
    check({tag, " alu_ctrl"},   32'(alu_ctrl),      32'(e.ctrl));
    check({tag, " ex_dest"},    32'(ex_dest),       32'(e.dest));
    check({tag, " ctl"},        32'({ex_reg_write, ex_mem_read, ex_mem_write,
                                     ex_mem_to_reg, ex_branch}), 32'(e.ctl));
    check({tag, " stall_count"}, 32'(stall_count),  32'(e.cnt));
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    id_t  add1, sub3, add4, and9, addi4, sw4;
    fwd_t nf;
    exp_t e;
    logic [CW-1:0] cnt_exp;

    add1  = mk_id(5'd1, 5'd2, 5'd3,  32'd5,   32'd7,   32'h0, ALU_ADD, 1'b0, 1'b1, 5'b10000);
    sub3  = mk_id(5'd3, 5'd5, 5'd6,  32'h11,  32'h22,  32'h0, ALU_SUB, 1'b0, 1'b1, 5'b10000);
    add4  = mk_id(5'd4, 5'd2, 5'd7,  32'h44,  32'h77,  32'h0, ALU_ADD, 1'b0, 1'b1, 5'b10000);
    and9  = mk_id(5'd9, 5'd10, 5'd11, 32'hF0, 32'hFF,  32'h0, ALU_AND, 1'b0, 1'b1, 5'b10000);
    addi4 = mk_id(5'd5, 5'd4, 5'd0,  32'h50,  32'h40,  32'h3, ALU_ADD, 1'b1, 1'b0, 5'b10000);
    sw4   = mk_id(5'd6, 5'd4, 5'd0,  32'h60,  32'h40,  32'h8, ALU_ADD, 1'b1, 1'b0, 5'b00100);
    nf    = mk_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Each row: ID/forwarding inputs for one cycle and the outputs expected in that cycle.
    vecs[0]  = '{add1, 1'b0, nf, bubble(2'd0)};
    vecs[1]  = '{sub3, 1'b0, nf, mk_exp(0, 1, 32'd5, 32'd7, 32'd7, ALU_ADD, 5'd3, 5'b10000, 2'd0)};
    vecs[2]  = '{sub3, 1'b0, mk_fwd(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB),
                 mk_exp(0, 1, 32'hAAAA, 32'h22, 32'h22, ALU_SUB, 5'd6, 5'b10000, 2'd0)};
    vecs[3]  = '{sub3, 1'b0, mk_fwd(0, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB),
                 mk_exp(0, 1, 32'hBBBB, 32'h22, 32'h22, ALU_SUB, 5'd6, 5'b10000, 2'd0)};
    vecs[4]  = '{lw4(32'h10), 1'b0, mk_fwd(1, 5'd0, 32'hAAAA, 1, 5'd0, 32'hBBBB),
                 mk_exp(0, 1, 32'h11, 32'h22, 32'h22, ALU_SUB, 5'd6, 5'b10000, 2'd0)};
    vecs[5]  = '{add4, 1'b0, nf, mk_exp(1, 1, 32'h100, 32'h10, 32'h999, ALU_ADD, 5'd4, 5'b11010, 2'd0)};
    vecs[6]  = '{add4, 1'b0, mk_fwd(1, 5'd4, 32'h10, 0, 5'd0, 32'h0), bubble(2'd1)};
    vecs[7]  = '{and9, 1'b0, mk_fwd(0, 5'd0, 32'h0, 1, 5'd4, 32'hDEAD),
                 mk_exp(0, 1, 32'hDEAD, 32'h77, 32'h77, ALU_ADD, 5'd7, 5'b10000, 2'd1)};
    vecs[8]  = '{lw4(32'h20), 1'b0, mk_fwd(1, 5'd10, 32'h55, 0, 5'd0, 32'h0),
                 mk_exp(0, 1, 32'hF0, 32'h55, 32'h55, ALU_AND, 5'd11, 5'b10000, 2'd1)};
    vecs[9]  = '{addi4, 1'b0, nf, mk_exp(0, 1, 32'h100, 32'h20, 32'h999, ALU_ADD, 5'd4, 5'b11010, 2'd1)};
    vecs[10] = '{lw4(32'h30), 1'b0, nf, mk_exp(0, 1, 32'h50, 32'h3, 32'h40, ALU_ADD, 5'd4, 5'b10000, 2'd1)};
    vecs[11] = '{sw4, 1'b0, nf, mk_exp(1, 1, 32'h100, 32'h30, 32'h999, ALU_ADD, 5'd4, 5'b11010, 2'd1)};
    vecs[12] = '{sw4, 1'b0, nf, bubble(2'd2)};
    vecs[13] = '{lw4(32'h40), 1'b0, nf, mk_exp(0, 1, 32'h60, 32'h8, 32'h40, ALU_ADD, 5'd4, 5'b00100, 2'd2)};
    vecs[14] = '{add4, 1'b1, nf, mk_exp(0, 1, 32'h100, 32'h40, 32'h999, ALU_ADD, 5'd4, 5'b11010, 2'd2)};
    vecs[15] = '{add4, 1'b0, nf, bubble(2'd2)};
    vecs[16] = '{lw4(32'h50), 1'b0, nf, mk_exp(0, 1, 32'h44, 32'h77, 32'h77, ALU_ADD, 5'd7, 5'b10000, 2'd2)};

    // Reset with live write-enable on the ID side must still leave EX empty.
    reset = 1'b1;
    drive(add4, 1'b0, nf);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all("reset", bubble(2'd0));
    $display("reset: checked cleared state");
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].id, vecs[i].flush, vecs[i].fwd);
      sb_q.push_back(vecs[i].exp);
      @(negedge clk);
      e = sb_q.pop_front();
      compare_all($sformatf("row%0d", i), e);
      $display("row%0d: stall=%0d ex_valid=%0d entr1=0x%0h entr2=0x%0h count=%0d",
               i, stall, ex_valid, alu_entr1, alu_entr2, stall_count);
      @(posedge clk);
      #1;
    end

    // Five more load-use hazards: the 2-bit counter must stop at 3.
    cnt_exp = 2'd2;
    for (int k = 0; k < 5; k++) begin
      drive(add4, 1'b0, nf);
      @(negedge clk);
      check($sformatf("sat%0d stall", k), 32'(stall), 32'd1);
      check($sformatf("sat%0d count_before", k), 32'(stall_count), 32'(cnt_exp));
      cnt_exp = (cnt_exp == 2'd3) ? 2'd3 : cnt_exp + 2'd1;
      @(posedge clk);
      #1;
      drive(lw4(32'h60), 1'b0, nf);
      @(negedge clk);
      check($sformatf("sat%0d bubble_valid", k), 32'(ex_valid), 32'd0);
      check($sformatf("sat%0d count_after", k), 32'(stall_count), 32'(cnt_exp));
      $display("sat%0d: stall_count=%0d", k, stall_count);
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
